// File: rtl/ads1115_ctrl.sv
// ADS1115 single-shot sequencer: config write, conversion wait, pointer write, 2-byte read.
// Drives the user-side handshake of the I2C master and reports NACK/timeout failures.
module ads1115_ctrl #(
    parameter int unsigned CLK_IN_FREQ_MHZ = 10,
    parameter logic [6:0]  DEV_ADDR        = 7'h48,
    parameter logic [15:0] CONFIG_WORD     = 16'h8583,
    parameter int unsigned CONV_WAIT_US    = 9000,
    parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
    input  logic        clk_in,
    input  logic        n_rst,
    input  logic        start_in,
    output logic        busy_out,
    output logic [15:0] sample_out,
    output logic        sample_valid_out,
    output logic        error_out,
    output logic        i2c_enable_out,
    output logic        i2c_rd_wr_out,
    output logic        i2c_continuous_out,
    output logic [6:0]  i2c_address_out,
    output logic [5:0]  i2c_data_bytes_out,
    output logic [7:0]  i2c_wr_data_out,
    input  logic        i2c_ready_in,
    input  logic        i2c_wr_valid_in,
    input  logic        i2c_rd_valid_in,
    input  logic [7:0]  i2c_rd_data_in
);

    localparam int unsigned WAIT_CYCLES = CONV_WAIT_US * CLK_IN_FREQ_MHZ;
    localparam int unsigned WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StCfg, StConvWait, StPtr, StRd, StDone, StError
    } state_e;

    typedef enum logic [1:0] {PhReq, PhAccept, PhRun} phase_e;

    state_e            r_state, w_state_next, w_after;
    phase_e            r_phase, w_phase_next;
    logic [1:0]        r_idx, w_idx_next;
    logic [TO_W-1:0]   r_wd, w_wd_next;
    logic [WAIT_W-1:0] r_wait, w_wait_next;
    logic [15:0]       r_rd_data, w_rd_data_next;
    logic [15:0]       r_sample, w_sample_next;
    logic              r_busy, w_busy_next;
    logic              r_enable, w_enable_next;
    logic [1:0]        w_nbytes;
    logic [7:0]        w_wr_byte;
    logic              w_valid;

    assign w_valid = (r_state == StRd) ? i2c_rd_valid_in : i2c_wr_valid_in;
    assign w_after = (r_state == StCfg) ? StConvWait : ((r_state == StPtr) ? StRd : StDone);

    always_comb begin
        w_nbytes  = 2'd0;
        w_wr_byte = 8'h00;
        case (r_state)
            StCfg: begin
                w_nbytes = 2'd3;
                case (r_idx)
                    2'd0:    w_wr_byte = 8'h01;
                    2'd1:    w_wr_byte = CONFIG_WORD[15:8];
                    2'd2:    w_wr_byte = CONFIG_WORD[7:0];
                    default: w_wr_byte = 8'h00;
                endcase
            end
            StPtr:   w_nbytes = 2'd1;
            StRd:    w_nbytes = 2'd2;
            default: w_nbytes = 2'd0;
        endcase
    end

    always_comb begin
        w_state_next   = r_state;
        w_phase_next   = r_phase;
        w_idx_next     = r_idx;
        w_wd_next      = r_wd;
        w_wait_next    = r_wait;
        w_rd_data_next = r_rd_data;
        w_sample_next  = r_sample;
        w_busy_next    = r_busy;
        w_enable_next  = 1'b0;
        case (r_state)
            StIdle: begin
                if (start_in) begin
                    w_state_next = StCfg;
                    w_phase_next = PhReq;
                    w_wd_next    = '0;
                    w_busy_next  = 1'b1;
                end
            end
            StConvWait: begin
                if (r_wait == WAIT_LAST) begin
                    w_state_next = StPtr;
                    w_phase_next = PhReq;
                    w_wd_next    = '0;
                    w_wait_next  = '0;
                end else begin
                    w_wait_next = r_wait + 1'b1;
                end
            end
            StCfg, StPtr, StRd: begin
                w_wd_next = r_wd + 1'b1;
                // Index saturates at the byte count so extra pulses are ignored.
                if (r_phase != PhReq && w_valid && r_idx != w_nbytes) begin
                    w_idx_next = r_idx + 2'd1;
                    if (r_state == StRd) begin
                        if (r_idx == 2'd0) w_rd_data_next[15:8] = i2c_rd_data_in;
                        else               w_rd_data_next[7:0]  = i2c_rd_data_in;
                    end
                end
                case (r_phase)
                    PhReq: begin
                        if (i2c_ready_in) begin
                            w_enable_next = 1'b1;
                            w_phase_next  = PhAccept;
                            w_wd_next     = '0;
                            w_idx_next    = '0;
                        end
                    end
                    PhAccept: begin
                        if (!i2c_ready_in) begin
                            w_phase_next = PhRun;
                            w_wd_next    = '0;
                        end
                    end
                    default: begin
                        if (i2c_ready_in) begin
                            w_phase_next = PhReq;
                            w_wd_next    = '0;
                            if (w_idx_next == w_nbytes) begin
                                w_state_next = w_after;
                                w_wait_next  = '0;
                                if (r_state == StRd) w_sample_next = w_rd_data_next;
                            end else begin
                                w_state_next = StError;
                            end
                        end
                    end
                endcase
                if (w_phase_next == r_phase && r_wd == TO_LAST) begin
                    w_state_next = StError;
                end
            end
            StDone, StError: begin
                w_state_next = StIdle;
                w_busy_next  = 1'b0;
            end
            default: begin
                w_state_next = StIdle;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!n_rst) begin
            r_state   <= StIdle;
            r_phase   <= PhReq;
            r_idx     <= '0;
            r_wd      <= '0;
            r_wait    <= '0;
            r_rd_data <= '0;
            r_sample  <= '0;
            r_busy    <= 1'b0;
            r_enable  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_phase   <= w_phase_next;
            r_idx     <= w_idx_next;
            r_wd      <= w_wd_next;
            r_wait    <= w_wait_next;
            r_rd_data <= w_rd_data_next;
            r_sample  <= w_sample_next;
            r_busy    <= w_busy_next;
            r_enable  <= w_enable_next;
        end
    end

    assign busy_out           = r_busy;
    assign sample_out         = r_sample;
    assign sample_valid_out   = (r_state == StDone);
    assign error_out          = (r_state == StError);
    assign i2c_enable_out     = r_enable;
    assign i2c_rd_wr_out      = (r_state == StRd);
    assign i2c_continuous_out = 1'b1;
    assign i2c_address_out    = DEV_ADDR;
    assign i2c_data_bytes_out = {4'd0, w_nbytes};
    assign i2c_wr_data_out    = w_wr_byte;

endmodule

// File: tb/tb_ads1115_ctrl.sv
// Directed bench for ads1115_ctrl: the initial block plays the I2C master and checks
// the handshake, sample results, NACK/timeout errors and reset behaviour.
module tb_ads1115_ctrl;

    logic        clk_in;
    logic        n_rst;
    logic        start_in;
    logic        busy_out;
    logic [15:0] sample_out;
    logic        sample_valid_out;
    logic        error_out;
    logic        i2c_enable_out;
    logic        i2c_rd_wr_out;
    logic        i2c_continuous_out;
    logic [6:0]  i2c_address_out;
    logic [5:0]  i2c_data_bytes_out;
    logic [7:0]  i2c_wr_data_out;
    logic        i2c_ready_in;
    logic        i2c_wr_valid_in;
    logic        i2c_rd_valid_in;
    logic [7:0]  i2c_rd_data_in;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_errp   = 0;

    ads1115_ctrl #(
        .CLK_IN_FREQ_MHZ(10),
        .DEV_ADDR       (7'h48),
        .CONFIG_WORD    (16'h8583),
        .CONV_WAIT_US   (1),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk_in            (clk_in),
        .n_rst             (n_rst),
        .start_in          (start_in),
        .busy_out          (busy_out),
        .sample_out        (sample_out),
        .sample_valid_out  (sample_valid_out),
        .error_out         (error_out),
        .i2c_enable_out    (i2c_enable_out),
        .i2c_rd_wr_out     (i2c_rd_wr_out),
        .i2c_continuous_out(i2c_continuous_out),
        .i2c_address_out   (i2c_address_out),
        .i2c_data_bytes_out(i2c_data_bytes_out),
        .i2c_wr_data_out   (i2c_wr_data_out),
        .i2c_ready_in      (i2c_ready_in),
        .i2c_wr_valid_in   (i2c_wr_valid_in),
        .i2c_rd_valid_in   (i2c_rd_valid_in),
        .i2c_rd_data_in    (i2c_rd_data_in)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(negedge clk_in) begin
        if (sample_valid_out) n_valid <= n_valid + 1;
        if (error_out)        n_errp  <= n_errp + 1;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_enable(input string tag);
        int n;
        n = 0;
        while (i2c_enable_out !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_enable"}, i2c_enable_out, 1);
    endtask

    // One master transaction: accept, deliver npulse valid pulses, then return ready.
    task automatic xfer(input string tag, input bit rd, input int nbytes,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input int npulse);
        logic [7:0] d;
        wait_enable(tag);
        check({tag, "_rdwr"}, i2c_rd_wr_out, rd);
        check({tag, "_nbytes"}, i2c_data_bytes_out, nbytes);
        i2c_ready_in = 1'b0;
        tick();
        check({tag, "_enable_pulse"}, i2c_enable_out, 0);
        for (int k = 0; k < npulse; k++) begin
            d = (k == 0) ? d0 : ((k == 1) ? d1 : d2);
            if (rd) begin
                i2c_rd_data_in  = d;
                i2c_rd_valid_in = 1'b1;
            end else begin
                check({tag, "_wrdata"}, i2c_wr_data_out, d);
                i2c_wr_valid_in = 1'b1;
            end
            tick();
            i2c_rd_valid_in = 1'b0;
            i2c_wr_valid_in = 1'b0;
            tick();
        end
        i2c_ready_in = 1'b1;
        tick();
    endtask

    task automatic start_meas(input string tag);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check({tag, "_busy"}, busy_out, 1);
    endtask

    task automatic run_meas(input string tag, input logic [7:0] msb, input logic [7:0] lsb);
        start_meas(tag);
        xfer({tag, "_cfg"}, 1'b0, 3, 8'h01, 8'h85, 8'h83, 3);
        xfer({tag, "_ptr"}, 1'b0, 1, 8'h00, 8'h00, 8'h00, 1);
        xfer({tag, "_rd"}, 1'b1, 2, msb, lsb, 8'h00, 2);
        check({tag, "_valid"}, sample_valid_out, 1);
        check({tag, "_sample"}, sample_out, {msb, lsb});
        tick();
        check({tag, "_valid_end"}, sample_valid_out, 0);
        check({tag, "_busy_end"}, busy_out, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy_out, 0);
        check({tag, "_sample"}, sample_out, 16'h0000);
        check({tag, "_valid"}, sample_valid_out, 0);
        check({tag, "_err"}, error_out, 0);
        check({tag, "_en"}, i2c_enable_out, 0);
        check({tag, "_rdwr"}, i2c_rd_wr_out, 0);
        check({tag, "_cont"}, i2c_continuous_out, 1);
        check({tag, "_addr"}, i2c_address_out, 7'h48);
        check({tag, "_nbytes"}, i2c_data_bytes_out, 0);
        check({tag, "_wrdata"}, i2c_wr_data_out, 0);
    endtask

    initial begin
        int v0;
        int e0;
        int n;
        n_rst           = 1'b0;
        start_in        = 1'b0;
        i2c_ready_in    = 1'b1;
        i2c_wr_valid_in = 1'b0;
        i2c_rd_valid_in = 1'b0;
        i2c_rd_data_in  = 8'h00;
        tick();
        tick();
        check_reset_values("reset");
        n_rst = 1'b1;
        tick();

        // 1: nominal measurement
        v0 = n_valid;
        e0 = n_errp;
        run_meas("nominal", 8'h12, 8'h34);
        check("nominal_valid_count", n_valid - v0, 1);
        check("nominal_no_error", n_errp - e0, 0);

        // 2: negative sample
        run_meas("negative", 8'hFF, 8'h38);

        // 3: NACK abort in config write
        v0 = n_valid;
        e0 = n_errp;
        start_meas("nack");
        xfer("nack_cfg", 1'b0, 3, 8'h01, 8'h85, 8'h83, 1);
        check("nack_error", error_out, 1);
        tick();
        check("nack_error_end", error_out, 0);
        check("nack_busy_end", busy_out, 0);
        check("nack_sample_kept", sample_out, 16'hFF38);
        check("nack_error_count", n_errp - e0, 1);
        check("nack_no_valid", n_valid - v0, 0);

        // 4: timeout after the pointer-write enable
        e0 = n_errp;
        start_meas("tmo");
        xfer("tmo_cfg", 1'b0, 3, 8'h01, 8'h85, 8'h83, 3);
        wait_enable("tmo_ptr");
        i2c_ready_in = 1'b0;
        n = 0;
        while (error_out !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("tmo_latency_in_window", (n >= 49 && n <= 51), 1);
        i2c_ready_in = 1'b1;
        tick();
        check("tmo_busy_end", busy_out, 0);
        check("tmo_error_count", n_errp - e0, 1);

        // 5: start while busy is ignored
        v0 = n_valid;
        start_meas("busy");
        xfer("busy_cfg", 1'b0, 3, 8'h01, 8'h85, 8'h83, 3);
        tick();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        xfer("busy_ptr", 1'b0, 1, 8'h00, 8'h00, 8'h00, 1);
        xfer("busy_rd", 1'b1, 2, 8'h0A, 8'hBC, 8'h00, 2);
        check("busy_sample", sample_out, 16'h0ABC);
        tick();
        for (int i = 0; i < 40; i++) tick();
        check("busy_enable_idle", i2c_enable_out, 0);
        check("busy_still_idle", busy_out, 0);
        check("busy_valid_count", n_valid - v0, 1);

        // 6: reset in the middle of the read
        v0 = n_valid;
        e0 = n_errp;
        start_meas("rst");
        xfer("rst_cfg", 1'b0, 3, 8'h01, 8'h85, 8'h83, 3);
        xfer("rst_ptr", 1'b0, 1, 8'h00, 8'h00, 8'h00, 1);
        wait_enable("rst_rd");
        i2c_ready_in = 1'b0;
        tick();
        i2c_rd_data_in  = 8'hAB;
        i2c_rd_valid_in = 1'b1;
        tick();
        i2c_rd_valid_in = 1'b0;
        n_rst = 1'b0;
        tick();
        check_reset_values("midrst");
        n_rst        = 1'b1;
        i2c_ready_in = 1'b1;
        tick();
        check("rst_no_pulses", (n_valid - v0) + (n_errp - e0), 0);
        run_meas("after_rst", 8'h56, 8'h78);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ads1115_ctrl.md
Name: ads1115_ctrl

Overview:
Sequencer that sits directly upstream of the team's I2C master and drives its user-side handshake to run one ADS1115 single-shot measurement per request. It writes the config register, waits the conversion time, sets the pointer to the conversion register, and reads two bytes. It then presents a signed 16-bit sample. It flags NACK-abort and timeout failures so the consumer never hangs.

Parameters:
CLK_IN_FREQ_MHZ, 10, system clock in MHz; sets the conversion wait length.
DEV_ADDR, 7'h48, ADS1115 7-bit slave address (ADDR pin to GND).
CONFIG_WORD, 16'h8583, value written to config register 0x01 (OS=1, single-shot).
CONV_WAIT_US, 9000, delay from config-write completion to pointer write; wait = CONV_WAIT_US*CLK_IN_FREQ_MHZ cycles.
TIMEOUT_CYCLES, 100000, per-transfer watchdog limit in clk_in cycles.

Ports:
clk_in  in  1  system clock, all logic on rising edge
n_rst  in  1  synchronous, active-low reset
start_in  in  1  request one measurement; sampled only in IDLE
busy_out  out  1  high from start acceptance until DONE/ERROR exit
sample_out  out  16  last good conversion result {MSB,LSB}, two's complement
sample_valid_out  out  1  one-cycle pulse when sample_out updates
error_out  out  1  one-cycle pulse on failed measurement
i2c_enable_out  out  1  one-cycle transaction request to master
i2c_rd_wr_out  out  1  1 read, 0 write
i2c_continuous_out  out  1  always 1: bytes of a transfer go back-to-back without repeated start
i2c_address_out  out  7  always DEV_ADDR
i2c_data_bytes_out  out  6  byte count of current transfer (3, 1 or 2)
i2c_wr_data_out  out  8  byte the master sends next
i2c_ready_in  in  1  master idle/ready
i2c_wr_valid_in  in  1  master pulse: one write byte done
i2c_rd_valid_in  in  1  master pulse: one read byte valid
i2c_rd_data_in  in  8  read byte, valid with i2c_rd_valid_in

Behaviour:
- Reset: n_rst sampled on clk_in rising edge only. When low, state goes to IDLE and all counters clear.
- Reset values: every output is 0 except i2c_address_out=DEV_ADDR and i2c_continuous_out=1. sample_out also resets to 0.
- Reset asserted mid-operation aborts immediately. No error pulse. The master is not informed; the next start waits for i2c_ready_in.
- States: IDLE, CFG, CONV_WAIT, PTR, RD, DONE, ERROR.
- Transfer sub-phases inside CFG, PTR and RD: REQ, ACCEPT, RUN.
  - REQ: wait for i2c_ready_in=1, then pulse i2c_enable_out for exactly 1 cycle with rd_wr and data_bytes stable. These two are held until the transfer ends.
  - ACCEPT: wait for i2c_ready_in=0.
  - RUN: wait for i2c_ready_in=1; the transfer is then complete.
- Byte accounting: a byte index starts at 0 at the enable pulse.
  - Write transfers: index increments on each i2c_wr_valid_in, and i2c_wr_data_out = byte[index].
  - Read transfers: index increments on each i2c_rd_valid_in.
- IDLE: when start_in=1, set busy_out=1 on the next cycle and go to CFG.
- CFG: write 3 bytes 0x01, CONFIG_WORD[15:8], CONFIG_WORD[7:0]. Completes only if exactly 3 wr_valid pulses were seen; then go to CONV_WAIT.
- CONV_WAIT: count CONV_WAIT_US*CLK_IN_FREQ_MHZ cycles, then go to PTR. Counter is wide enough for the product.
- PTR: write 1 byte 0x00; requires 1 wr_valid pulse; then go to RD.
- RD: read 2 bytes, i2c_rd_wr_out=1. First rd_valid captures MSB, second captures LSB.
- DONE (1 cycle): load sample_out, pulse sample_valid_out, clear busy_out, return to IDLE.
- Failure conditions (master returned ready with fewer valid pulses than data_bytes, e.g. retries exhausted on NACK):
  - Short count at RUN end.
  - Watchdog reaching TIMEOUT_CYCLES in any of REQ/ACCEPT/RUN. Watchdog clears on each sub-phase entry.
- ERROR (1 cycle): pulse error_out, clear busy_out, return to IDLE. sample_out keeps its previous value.
- start_in while busy is ignored. It is not queued.
- Extra valid pulses beyond data_bytes are ignored; the index saturates.
- Latency: sample_valid_out asserts 1 cycle after the cycle i2c_ready_in returns high at RD end.

Test Plan:
1. Nominal read, CONV_WAIT_US=1 with a bus model ACKing everything:
   - Master sees write 48: 01 85 83, then write 00, then read.
   - Slave returns 0x12, 0x34 → sample_out=16'h1234 with a one-cycle sample_valid_out; busy_out low afterwards; error_out never pulses.
2. Negative value: slave returns 0xFF, 0x38 → sample_out=16'hFF38 (−200 as signed).
3. NACK abort: the master model returns ready after only 1 wr_valid in CFG.
   - error_out pulses once; no sample_valid_out; sample_out unchanged from the previous test.
4. Timeout: TIMEOUT_CYCLES=50 and i2c_ready_in held low after the PTR enable → error_out pulses 50±1 cycles after ACCEPT entry; FSM returns to IDLE.
5. Start while busy: pulse start_in during CONV_WAIT → exactly one measurement and one sample_valid_out.
6. Reset mid-RD: n_rst low for 1 cycle after the first rd_valid.
   - All outputs return to reset values at the next edge, with no error or valid pulse.
   - A subsequent start completes normally.
